// File: rtl/moore_seq_gen_if.sv
// Control/status bundle of the serial pattern transmitter.
// The master drives the request side; the slave is the transmitter itself.
interface moore_seq_gen_if #(
    parameter int PAT_W = 4,
    parameter int RPT_W = 4
);
    logic             start;
    logic             abort;
    logic [PAT_W-1:0] pat_in;
    logic [RPT_W-1:0] rpt_in;
    logic             out;
    logic             busy;
    logic             done;
    logic [2:0]       present_state;

    modport master (
        output start, abort, pat_in, rpt_in,
        input  out, busy, done, present_state
    );

    modport slave (
        input  start, abort, pat_in, rpt_in,
        output out, busy, done, present_state
    );
endinterface

// File: rtl/moore_seq_gen.sv
// Serial pattern transmitter: latches a pattern on start and shifts it out
// MSB-first on a registered line, rpt times, with optional idle gaps between.
module moore_seq_gen #(
    parameter int   PAT_W    = 4,
    parameter int   RPT_W    = 4,
    parameter int   GAP_CYC  = 0,
    parameter logic IDLE_BIT = 1'b0
) (
    input logic             clk,
    input logic             rst,
    moore_seq_gen_if.slave  bus
);
    localparam int BIT_W = $clog2(PAT_W);
    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(PAT_W - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SEND = 3'd1,
        S_GAP  = 3'd2,
        S_DONE = 3'd3
    } state_t;

    state_t           state;
    logic [PAT_W-1:0] pat_q;
    logic [PAT_W-1:0] shreg;
    logic [BIT_W-1:0] bitcnt;
    logic [RPT_W-1:0] rep;
    logic [GAP_W-1:0] gapcnt;
    logic             out_q;
    logic             busy_q;
    logic             done_q;

    assign bus.out           = out_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.present_state = state;

    // NOTE: every register here is state, so only non-blocking assignments;
    // the pattern copy is a small register, not a memory, so it is reset too.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_IDLE;
            pat_q  <= '0;
            shreg  <= '0;
            bitcnt <= '0;
            rep    <= '0;
            gapcnt <= '0;
            out_q  <= IDLE_BIT;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        state  <= S_SEND;
                        pat_q  <= bus.pat_in;
                        shreg  <= bus.pat_in;
                        rep    <= (bus.rpt_in == '0) ? RPT_W'(1) : bus.rpt_in;
                        bitcnt <= '0;
                        out_q  <= bus.pat_in[PAT_W-1];
                        busy_q <= 1'b1;
                    end
                end

                S_SEND: begin
                    if (bus.abort) begin
                        state  <= S_IDLE;
                        out_q  <= IDLE_BIT;
                        busy_q <= 1'b0;
                    end else if (bitcnt != BIT_LAST) begin
                        // shreg MSB is the bit currently on the line
                        bitcnt <= bitcnt + BIT_W'(1);
                        shreg  <= shreg << 1;
                        out_q  <= shreg[PAT_W-2];
                    end else if (rep == RPT_W'(1)) begin
                        state  <= S_DONE;
                        bitcnt <= '0;
                        out_q  <= IDLE_BIT;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        rep    <= rep - RPT_W'(1);
                        bitcnt <= '0;
                        if (GAP_CYC == 0) begin
                            shreg <= pat_q;
                            out_q <= pat_q[PAT_W-1];
                        end else begin
                            state  <= S_GAP;
                            gapcnt <= '0;
                            out_q  <= IDLE_BIT;
                        end
                    end
                end

                S_GAP: begin
                    if (bus.abort) begin
                        state  <= S_IDLE;
                        gapcnt <= '0;
                        out_q  <= IDLE_BIT;
                        busy_q <= 1'b0;
                    end else if (gapcnt == GAP_LAST) begin
                        state  <= S_SEND;
                        gapcnt <= '0;
                        shreg  <= pat_q;
                        out_q  <= pat_q[PAT_W-1];
                    end else begin
                        gapcnt <= gapcnt + GAP_W'(1);
                    end
                end

                S_DONE: begin
                    state  <= S_IDLE;
                    out_q  <= IDLE_BIT;
                    busy_q <= 1'b0;
                end

                default: begin
                    state  <= S_IDLE;
                    out_q  <= IDLE_BIT;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_moore_seq_gen.sv
// Bench for moore_seq_gen: two instances (back-to-back and 2-cycle gap) share
// stimulus; a per-instance queue of expected per-cycle observations is checked.
module tb_moore_seq_gen;
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_SEND = 3'd1;
    localparam logic [2:0] ST_GAP  = 3'd2;
    localparam logic [2:0] ST_DONE = 3'd3;

    // {present_state, out, busy, done}
    typedef logic [5:0] obs_t;

    typedef struct {
        logic [3:0] pat;
        logic [3:0] rpt;
        int         restart;
        int         busy0;
        int         busy2;
        int         det0;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] pat = '0;
    logic [3:0] rpt = '0;

    obs_t q0[$];
    obs_t q2[$];
    int   errors = 0;
    int   checks = 0;
    vec_t vecs[6];

    always #5 clk = ~clk;

    moore_seq_gen_if #(.PAT_W(4), .RPT_W(4)) if0 ();
    moore_seq_gen_if #(.PAT_W(4), .RPT_W(4)) if2 ();

    assign if0.start  = start;
    assign if0.abort  = abort;
    assign if0.pat_in = pat;
    assign if0.rpt_in = rpt;
    assign if2.start  = start;
    assign if2.abort  = abort;
    assign if2.pat_in = pat;
    assign if2.rpt_in = rpt;

    moore_seq_gen #(.PAT_W(4), .RPT_W(4), .GAP_CYC(0), .IDLE_BIT(1'b0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (if0)
    );

    moore_seq_gen #(.PAT_W(4), .RPT_W(4), .GAP_CYC(2), .IDLE_BIT(1'b0)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (if2)
    );

    function automatic obs_t obs0();
        return {if0.present_state, if0.out, if0.busy, if0.done};
    endfunction

    function automatic obs_t obs2();
        return {if2.present_state, if2.out, if2.busy, if2.done};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void push_exp(input int sel, input obs_t v);
        if (sel == 0) q0.push_back(v);
        else          q2.push_back(v);
    endfunction

    // Expected per-cycle trace from cycle 1 after the start edge.
    function automatic void model(input int sel, input int gap, input logic [3:0] p,
                                  input logic [3:0] r);
        int reps;
        reps = (r == 4'd0) ? 1 : int'(r);
        for (int k = 0; k < reps; k++) begin
            for (int b = 3; b >= 0; b--) push_exp(sel, {ST_SEND, p[b], 1'b1, 1'b0});
            if (k < reps - 1)
                for (int g = 0; g < gap; g++) push_exp(sel, {ST_GAP, 1'b0, 1'b1, 1'b0});
        end
        push_exp(sel, {ST_DONE, 1'b0, 1'b0, 1'b1});
        push_exp(sel, {ST_IDLE, 1'b0, 1'b0, 1'b0});
        push_exp(sel, {ST_IDLE, 1'b0, 1'b0, 1'b0});
    endfunction

    task automatic run_vector(input int idx, input vec_t v);
        int         nbusy0;
        int         nbusy2;
        int         det;
        int         nwin;
        logic [3:0] win;
        obs_t       e;
        nbusy0 = 0; nbusy2 = 0; det = 0; nwin = 0; win = '0;
        model(0, 0, v.pat, v.rpt);
        model(2, 2, v.pat, v.rpt);
        pat   = v.pat;
        rpt   = v.rpt;
        start = 1'b1;
        for (int cyc = 1; cyc <= 200 && (q0.size() > 0 || q2.size() > 0); cyc++) begin
            @(posedge clk);
            #1;
            start = (cyc == v.restart);
            if (cyc == 1) begin
                pat = ~v.pat;
                rpt = 4'd5;
            end
            if (q0.size() > 0) begin
                e = q0.pop_front();
                check($sformatf("v%0d_gap0_c%0d", idx, cyc), 32'(obs0()), 32'(e));
            end
            if (q2.size() > 0) begin
                e = q2.pop_front();
                check($sformatf("v%0d_gap2_c%0d", idx, cyc), 32'(obs2()), 32'(e));
            end
            if (if0.busy) begin
                nbusy0++;
                win = {win[2:0], if0.out};
                nwin++;
                if (nwin >= 4 && win == 4'b1101) det++;
            end
            if (if2.busy) nbusy2++;
        end
        check($sformatf("v%0d_timeout", idx), 32'(q0.size() + q2.size()), 32'd0);
        q0.delete();
        q2.delete();
        start = 1'b0;
        check($sformatf("v%0d_busy_cycles_gap0", idx), 32'(nbusy0), 32'(v.busy0));
        check($sformatf("v%0d_busy_cycles_gap2", idx), 32'(nbusy2), 32'(v.busy2));
        if (v.det0 >= 0)
            check($sformatf("v%0d_detections", idx), 32'(det), 32'(v.det0));
        pat = v.pat;
        rpt = v.rpt;
    endtask

    // Abort after cycle at_cyc has been observed; both instances must drop to IDLE.
    task automatic abort_test(input int at_cyc, input logic [2:0] st0, input logic [2:0] st2);
        pat   = 4'b1101;
        rpt   = 4'd2;
        start = 1'b1;
        for (int cyc = 1; cyc <= at_cyc; cyc++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        check($sformatf("abort%0d_pre_state_gap0", at_cyc), 32'(if0.present_state), 32'(st0));
        check($sformatf("abort%0d_pre_state_gap2", at_cyc), 32'(if2.present_state), 32'(st2));
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check($sformatf("abort%0d_post_gap0", at_cyc), 32'(obs0()), 32'({ST_IDLE, 3'b000}));
        check($sformatf("abort%0d_post_gap2", at_cyc), 32'(obs2()), 32'({ST_IDLE, 3'b000}));
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("abort%0d_quiet_gap0_%0d", at_cyc, k), 32'(obs0()), 32'({ST_IDLE, 3'b000}));
            check($sformatf("abort%0d_quiet_gap2_%0d", at_cyc, k), 32'(obs2()), 32'({ST_IDLE, 3'b000}));
        end
    endtask

    initial begin
        vecs[0] = '{pat: 4'b1101, rpt: 4'd1,  restart: 0, busy0: 4,  busy2: 4,  det0: 1};
        vecs[1] = '{pat: 4'b1101, rpt: 4'd2,  restart: 0, busy0: 8,  busy2: 10, det0: 2};
        vecs[2] = '{pat: 4'b1101, rpt: 4'd0,  restart: 2, busy0: 4,  busy2: 4,  det0: 1};
        vecs[3] = '{pat: 4'b1010, rpt: 4'd3,  restart: 3, busy0: 12, busy2: 16, det0: -1};
        vecs[4] = '{pat: 4'b0110, rpt: 4'd2,  restart: 0, busy0: 8,  busy2: 10, det0: -1};
        vecs[5] = '{pat: 4'b1000, rpt: 4'd15, restart: 0, busy0: 60, busy2: 88, det0: -1};

        #2 rst = 1'b0;
        #1;
        check("reset_gap0", 32'(obs0()), 32'({ST_IDLE, 3'b000}));
        check("reset_gap2", 32'(obs2()), 32'({ST_IDLE, 3'b000}));
        repeat (2) @(posedge clk);
        #1;
        check("reset_held_gap0", 32'(obs0()), 32'({ST_IDLE, 3'b000}));
        @(negedge clk);
        rst = 1'b1;

        foreach (vecs[i]) run_vector(i, vecs[i]);

        abort_test(2, ST_SEND, ST_SEND);
        run_vector(10, vecs[0]);
        abort_test(5, ST_SEND, ST_GAP);
        run_vector(11, vecs[1]);

        // Asynchronous reset in the middle of the gap.
        pat   = 4'b1101;
        rpt   = 4'd2;
        start = 1'b1;
        for (int cyc = 1; cyc <= 5; cyc++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        check("rst_mid_gap_pre_state", 32'(if2.present_state), 32'(ST_GAP));
        #2 rst = 1'b0;
        #1;
        check("rst_mid_gap_async_gap2", 32'(obs2()), 32'({ST_IDLE, 3'b000}));
        check("rst_mid_gap_async_gap0", 32'(obs0()), 32'({ST_IDLE, 3'b000}));
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("rst_after_quiet_gap2_%0d", k), 32'(obs2()), 32'({ST_IDLE, 3'b000}));
        end
        run_vector(12, vecs[1]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
